uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer placed directly downstream of the UART receiver. It captures each valid received byte into a first-word-fall-through FIFO, and the consumer drains it with a ready/valid handshake. It also counts parity errors, stop-bit errors and overflow drops reported by the receiver, and exposes fill level and sticky status for software or debug logic.

Parameters:
PACK_SIZE, 8, data width per byte; must match the receiver's packet size.
DEPTH, 16, number of FIFO entries; power of two, at least 2.
CNT_WIDTH, 8, width of each error/drop counter.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
rx_byte_data  input  PACK_SIZE  received byte from the UART receiver.
rx_byte_valid  input  1  receiver byte-valid; only the rising edge is used as the write strobe.
par_error  input  1  receiver parity-error pulse.
stop_error  input  1  receiver stop-bit-error pulse.
rd_data  output  PACK_SIZE  head-of-FIFO byte; 0 when empty.
rd_valid  output  1  FIFO non-empty.
rd_ready  input  1  consumer accepts rd_data this cycle.
count  output  $clog2(DEPTH)+1  current number of stored entries.
full  output  1  count == DEPTH.
overflow  output  1  sticky; set when a byte is dropped.
par_err_cnt  output  CNT_WIDTH  saturating count of par_error pulses.
stop_err_cnt  output  CNT_WIDTH  saturating count of stop_error pulses.
drop_cnt  output  CNT_WIDTH  saturating count of dropped bytes.
clr_status  input  1  synchronous clear of overflow and all three counters.

Behaviour:
- Reset (asynchronous, active-high):
  - Write pointer, read pointer and count go to 0.
  - Outputs after reset: rd_valid=0, rd_data=0, full=0, overflow=0, all counters=0.
  - Memory contents are not reset.
  - The rx_byte_valid edge-detect register resets to 1, so a valid level held across reset release does not write.
  - Asserting rst mid-operation discards all stored data immediately.
- Write strobe: wr = rx_byte_valid & ~rx_byte_valid_d, where rx_byte_valid_d is registered every cycle. A level held high for N cycles writes exactly once.
- Read: pop = rd_valid & rd_ready.
- Empty to non-empty latency: a byte written at edge k makes rd_valid=1 and rd_data equal to that byte after edge k. There is no extra pipeline stage.
- rd_data is a combinational read of mem[rd_ptr], gated to 0 when count == 0.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally at DEPTH-1 -> 0. count is tracked separately, so full and empty are unambiguous.
- Push/pop cases:
  - wr & ~full: store the byte at wr_ptr, wr_ptr+1.
  - pop: rd_ptr+1.
  - count += wr_accepted - pop.
- Full case:
  - wr & full & ~pop: byte dropped; overflow<=1; drop_cnt increments (saturating). Stored data is unchanged.
  - wr & full & pop: both occur; count stays DEPTH; no drop, no overflow.
- Empty case: pop cannot occur because rd_valid=0. A wr while empty is accepted.
- rd_ready while rd_valid=0 is ignored.
- par_error / stop_error: each cycle the input is high increments its counter. The receiver issues single-cycle pulses.
- Byte handling on errors: the receiver suppresses valid on bad frames, so the FIFO never stores them. This block does no additional filtering.
- Counters saturate at all ones and never wrap.
- clr_status:
  - On the next edge, overflow<=0 and each counter<=0.
  - If the counter's increment event occurs in the same cycle, the counter loads 1 and overflow loads the new drop condition, so no event is lost.
  - clr_status does not touch FIFO data, pointers or count.
- All state updates occur on posedge clk, except reset.

Test Plan:
- Reset, then write three bytes 0x11, 0x22, 0x33 with one-cycle valid pulses, rd_ready=0.
  -> count=3, rd_valid=1, rd_data=0x11 one cycle after the first write.
  -> Then rd_ready=1 yields 0x11, 0x22, 0x33 on consecutive cycles, then rd_valid=0, rd_data=0.
- Hold rx_byte_valid high 10 cycles with data 0xA5.
  -> Exactly one entry stored, count=1.
- DEPTH=16: write 17 bytes 0x00..0x10 with rd_ready=0.
  -> full=1, count=16, overflow=1, drop_cnt=1.
  -> Reads return 0x00..0x0F; 0x10 is lost.
- At full, write 0x55 in the same cycle as a pop.
  -> count stays 16, overflow and drop_cnt unchanged, 0x55 is read last.
- Pulse par_error 3 times and stop_error 300 times (CNT_WIDTH=8).
  -> par_err_cnt=3, stop_err_cnt=255 (saturated).
  -> clr_status coinciding with a par_error pulse gives par_err_cnt=1, stop_err_cnt=0.
- Assert rst asynchronously (between clock edges) with count=5.
  -> count=0, rd_valid=0, counters=0 immediately.
  -> rx_byte_valid held high through release causes no write.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: first-word-fall-through FIFO
// drained by ready/valid, plus saturating error/drop counters and sticky overflow.
module uart_rx_fifo #(
  parameter int PACK_SIZE = 8,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PACK_SIZE-1:0]     rx_byte_data,
  input  logic                     rx_byte_valid,
  input  logic                     par_error,
  input  logic                     stop_error,
  output logic [PACK_SIZE-1:0]     rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [CNT_WIDTH-1:0]     par_err_cnt,
  output logic [CNT_WIDTH-1:0]     stop_err_cnt,
  output logic [CNT_WIDTH-1:0]     drop_cnt,
  input  logic                     clr_status
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [PACK_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 rx_byte_valid_d;
  logic                 wr;
  logic                 pop;
  logic                 wr_accept;
  logic                 drop;

  assign wr        = rx_byte_valid & ~rx_byte_valid_d;
  assign full      = (count == FULL_LVL);
  assign rd_valid  = (count != '0);
  assign pop       = rd_valid & rd_ready;
  // At full a simultaneous pop frees the slot the write lands in (wr_ptr == rd_ptr).
  assign wr_accept = wr & (~full | pop);
  assign drop      = wr & full & ~pop;
  assign rd_data   = rd_valid ? mem[rd_ptr] : '0;

  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cur,
                                                    input logic ev, input logic clr);
    if (clr)
      return {{(CNT_WIDTH-1){1'b0}}, ev};
    if (ev && (cur != '1))
      return cur + 1'b1;
    return cur;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_accept)
      mem[wr_ptr] <= rx_byte_data;
  end

  // Edge detector resets high so a level held through reset release is not a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_byte_valid_d <= 1'b1;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
    end else begin
      rx_byte_valid_d <= rx_byte_valid;
      if (wr_accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_accept} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow     <= 1'b0;
      par_err_cnt  <= '0;
      stop_err_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      overflow     <= clr_status ? drop : (overflow | drop);
      par_err_cnt  <= cnt_next(par_err_cnt, par_error, clr_status);
      stop_err_cnt <= cnt_next(stop_err_cnt, stop_error, clr_status);
      drop_cnt     <= cnt_next(drop_cnt, drop, clr_status);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a byte queue holds what the consumer should see,
// and counters/flags are compared against values derived from the stimulus.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_byte_data;
  logic       rx_byte_valid;
  logic       par_error;
  logic       stop_error;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic [7:0] par_err_cnt;
  logic [7:0] stop_err_cnt;
  logic [7:0] drop_cnt;
  logic       clr_status;

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;

  uart_rx_fifo #(.PACK_SIZE(8), .DEPTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .rx_byte_data(rx_byte_data), .rx_byte_valid(rx_byte_valid),
    .par_error(par_error), .stop_error(stop_error),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .count(count), .full(full), .overflow(overflow),
    .par_err_cnt(par_err_cnt), .stop_err_cnt(stop_err_cnt), .drop_cnt(drop_cnt),
    .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle valid pulse; the bench decides whether the byte should be kept.
  task automatic write_byte(input logic [7:0] b);
    rx_byte_data  = b;
    rx_byte_valid = 1'b1;
    if (sb.size() < 16) sb.push_back(b);
    step();
    rx_byte_valid = 1'b0;
    step();
  endtask

  task automatic drain(input string tag);
    rd_ready = 1'b1;
    while (sb.size() > 0) begin
      exp_b = sb.pop_front();
      check({tag, "_valid"}, rd_valid, 1);
      check({tag, "_data"}, rd_data, exp_b);
      step();
    end
    rd_ready = 1'b0;
    check({tag, "_empty_valid"}, rd_valid, 0);
    check({tag, "_empty_data"}, rd_data, 0);
  endtask

  initial begin
    rst = 1'b1; rx_byte_data = '0; rx_byte_valid = 1'b0; par_error = 1'b0;
    stop_error = 1'b0; rd_ready = 1'b0; clr_status = 1'b0;
    repeat (3) step();
    check("rst_count", count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cnts", {par_err_cnt, stop_err_cnt, drop_cnt}, 0);
    rst = 1'b0;
    step();

    // Three single-cycle writes; head visible right after the first edge.
    rx_byte_data = 8'h11; rx_byte_valid = 1'b1; sb.push_back(8'h11);
    step();
    check("first_valid", rd_valid, 1);
    check("first_data", rd_data, 8'h11);
    check("first_count", count, 1);
    rx_byte_valid = 1'b0;
    step();
    write_byte(8'h22);
    write_byte(8'h33);
    check("three_count", count, 3);
    drain("three");
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("ready_when_empty", count, 0);

    // Level held for ten cycles writes once.
    rx_byte_data = 8'hA5; rx_byte_valid = 1'b1; sb.push_back(8'hA5);
    repeat (10) step();
    rx_byte_valid = 1'b0;
    step();
    check("held_count", count, 1);
    drain("held");

    // Fill past capacity; pointers also wrap here.
    for (int i = 0; i < 17; i++) write_byte(8'(i));
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    check("fill_ovf", overflow, 1);
    check("fill_drop", drop_cnt, 1);

    // Write and pop together at full.
    rx_byte_data = 8'h55; rx_byte_valid = 1'b1; rd_ready = 1'b1;
    exp_b = sb.pop_front();
    check("fullrw_head", rd_data, exp_b);
    sb.push_back(8'h55);
    step();
    rx_byte_valid = 1'b0; rd_ready = 1'b0;
    check("fullrw_count", count, 16);
    check("fullrw_ovf", overflow, 1);
    check("fullrw_drop", drop_cnt, 1);
    step();
    drain("fullrw");

    // Error counters and saturation.
    for (int i = 0; i < 3; i++) begin
      par_error = 1'b1; step(); par_error = 1'b0; step();
    end
    for (int i = 0; i < 300; i++) begin
      stop_error = 1'b1; step(); stop_error = 1'b0; step();
    end
    check("par_cnt", par_err_cnt, 3);
    check("stop_sat", stop_err_cnt, 255);
    clr_status = 1'b1; par_error = 1'b1;
    step();
    clr_status = 1'b0; par_error = 1'b0;
    check("clr_par", par_err_cnt, 1);
    check("clr_stop", stop_err_cnt, 0);
    check("clr_drop", drop_cnt, 0);
    check("clr_ovf", overflow, 0);

    // Asynchronous reset mid-operation with valid held through release.
    for (int i = 0; i < 5; i++) write_byte(8'h80 + 8'(i));
    check("pre_rst_count", count, 5);
    #3;
    rst = 1'b1; rx_byte_valid = 1'b1; rx_byte_data = 8'hEE;
    #1;
    check("async_count", count, 0);
    check("async_valid", rd_valid, 0);
    check("async_par", par_err_cnt, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step();
    check("held_rel_count", count, 0);
    check("held_rel_valid", rd_valid, 0);
    rx_byte_valid = 1'b0;
    step();
    write_byte(8'h77);
    check("post_rst_count", count, 1);
    drain("post_rst");

    $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
    $finish;
  end

endmodule
